// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - read-mode type and width helpers for sync_fifo_ext
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - unreset storage, one synchronous write port, one asynchronous read port
module fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - synchronous FIFO with STD/FWFT read modes, thresholds and sticky errors
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter  int         DATA_W = 32,
    parameter  int         DEPTH  = 16,
    parameter  fifo_mode_e MODE   = FIFO_STD,
    localparam int         PTR_W  = ptr_width(DEPTH),
    localparam int         CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_flush,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    input  logic [CNT_W-1:0]  i_afull_th,
    input  logic [CNT_W-1:0]  i_aempty_th,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf,
    output logic              o_udf,
    input  logic              i_clr_err
);

    logic [PTR_W-1:0]  wrptr, rdptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head, rd_q;
    logic              rdvalid_q, ovf_q, udf_q;
    logic              rd_acc, wr_acc, ovf_set, udf_set;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (count == '0);
    assign o_full  = (count == CNT_W'(DEPTH));

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = i_rden & ~o_empty;
    assign wr_acc = i_wren & (~o_full | rd_acc);

    // Flush swallows any concurrent request, so it must not be reported as an error.
    assign ovf_set = i_wren & ~wr_acc & ~i_flush;
    assign udf_set = i_rden & o_empty & ~i_flush;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~i_flush),
        .waddr (wrptr),
        .wdata (i_wrdata),
        .raddr (rdptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count     <= '0;
            rd_q      <= '0;
            rdvalid_q <= 1'b0;
        end else if (i_flush) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count     <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            if (wr_acc) wrptr <= ptr_inc(wrptr);
            if (rd_acc) begin
                rdptr <= ptr_inc(rdptr);
                rd_q  <= head;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end
            rdvalid_q <= rd_acc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~i_clr_err);
            udf_q <= udf_set | (udf_q & ~i_clr_err);
        end
    end

    // FWFT drives zero while empty so the unreset storage never leaks onto o_rddata.
    assign o_rddata  = (MODE == FIFO_FWFT) ? (o_empty ? '0 : head) : rd_q;
    assign o_rdvalid = (MODE == FIFO_FWFT) ? ~o_empty : rdvalid_q;

    assign o_count     = count;
    assign o_alm_full  = (count >= i_afull_th);
    assign o_alm_empty = (count <= i_aempty_th);
    assign o_ovf       = ovf_q;
    assign o_udf       = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - directed bench for sync_fifo_ext in STD and FWFT modes
module tb_sync_fifo_ext;
    import sync_fifo_pkg::*;

    localparam int DW = 16;
    localparam int DP = 6;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, i_flush, i_wren, i_rden, i_clr_err;
    logic [DW-1:0] i_wrdata;
    logic [CW-1:0] i_afull_th, i_aempty_th;

    logic [DW-1:0] s_rddata, f_rddata;
    logic          s_rdvalid, s_full, s_empty, s_alm_full, s_alm_empty, s_ovf, s_udf;
    logic          f_rdvalid, f_full, f_empty, f_alm_full, f_alm_empty, f_ovf, f_udf;
    logic [CW-1:0] s_count, f_count;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] exp_tail [6] = '{16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h00AA};

    sync_fifo_ext #(.DATA_W(DW), .DEPTH(DP), .MODE(FIFO_STD)) u_s (
        .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
        .i_rden(i_rden), .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_full(s_full),
        .o_empty(s_empty), .o_alm_full(s_alm_full), .o_alm_empty(s_alm_empty),
        .i_afull_th(i_afull_th), .i_aempty_th(i_aempty_th), .o_count(s_count),
        .o_ovf(s_ovf), .o_udf(s_udf), .i_clr_err(i_clr_err)
    );

    sync_fifo_ext #(.DATA_W(DW), .DEPTH(DP), .MODE(FIFO_FWFT)) u_f (
        .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_wren(i_wren), .i_wrdata(i_wrdata),
        .i_rden(i_rden), .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full),
        .o_empty(f_empty), .o_alm_full(f_alm_full), .o_alm_empty(f_alm_empty),
        .i_afull_th(i_afull_th), .i_aempty_th(i_aempty_th), .o_count(f_count),
        .o_ovf(f_ovf), .o_udf(f_udf), .i_clr_err(i_clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; i_flush = 1'b0; i_wren = 1'b0; i_rden = 1'b0; i_clr_err = 1'b0;
        i_wrdata = '0; i_afull_th = 3'd4; i_aempty_th = 3'd1;
        tick(); tick();
        chk("rst_count",     32'(s_count), 0);
        chk("rst_empty",     32'(s_empty), 1);
        chk("rst_full",      32'(s_full), 0);
        chk("rst_rdvalid",   32'(s_rdvalid), 0);
        chk("rst_rddata",    32'(s_rddata), 0);
        chk("rst_ovf",       32'(s_ovf), 0);
        chk("rst_udf",       32'(s_udf), 0);
        chk("rst_alm_empty", 32'(s_alm_empty), 1);
        chk("rst_alm_full",  32'(s_alm_full), 0);
        chk("rst_f_rdvalid", 32'(f_rdvalid), 0);
        rstn = 1'b1;
        tick();

        i_wren = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            i_wrdata = 16'(k);
            tick();
            chk("wr_count",     32'(s_count), k);
            chk("wr_alm_empty", 32'(s_alm_empty), (k <= 1) ? 1 : 0);
            chk("wr_alm_full",  32'(s_alm_full), (k >= 4) ? 1 : 0);
            if (k == 5) begin
                i_afull_th = 3'd6;
                #1;
                chk("afull_th_change", 32'(s_alm_full), 0);
                i_afull_th = 3'd4;
            end
        end
        chk("full_flag",  32'(s_full), 1);
        chk("f_head_fwft", 32'(f_rddata), 32'h0001);
        i_wrdata = 16'h0007;
        tick();
        i_wren = 1'b0;
        chk("ovf_count", 32'(s_count), 6);
        chk("ovf_set",   32'(s_ovf), 1);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("ovf_clr", 32'(s_ovf), 0);

        for (int k = 1; k <= 6; k++) begin
            chk("f_head",    32'(f_rddata), k);
            chk("f_rdvalid", 32'(f_rdvalid), 1);
            i_rden = 1'b1;
            tick();
            i_rden = 1'b0;
            chk("s_rddata",  32'(s_rddata), k);
            chk("s_rdvalid", 32'(s_rdvalid), 1);
        end
        chk("drain_empty", 32'(s_empty), 1);
        tick();
        chk("idle_rdvalid", 32'(s_rdvalid), 0);
        chk("idle_hold",    32'(s_rddata), 32'h0006);

        i_wren = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_wrdata = 16'(16'h0011 + k);
            tick();
        end
        i_rden = 1'b1; i_wrdata = 16'h00AA;
        tick();
        i_wren = 1'b0;
        chk("rw_full_count", 32'(s_count), 6);
        chk("rw_full_data",  32'(s_rddata), 32'h0011);
        chk("rw_full_ovf",   32'(s_ovf), 0);
        for (int k = 0; k < 6; k++) begin
            chk("wrap_f_head", 32'(f_rddata), 32'(exp_tail[k]));
            tick();
            chk("wrap_s_data", 32'(s_rddata), 32'(exp_tail[k]));
        end
        i_rden = 1'b0;
        chk("wrap_empty", 32'(s_empty), 1);

        i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 16'h0055;
        tick();
        i_wren = 1'b0; i_rden = 1'b0;
        chk("empty_rw_count",   32'(s_count), 1);
        chk("empty_rw_rdvalid", 32'(s_rdvalid), 0);
        chk("empty_rw_udf",     32'(s_udf), 1);
        chk("empty_rw_f_data",  32'(f_rddata), 32'h0055);
        i_rden = 1'b1; i_clr_err = 1'b1;
        tick();
        i_rden = 1'b0; i_clr_err = 1'b0;
        chk("pop55_data", 32'(s_rddata), 32'h0055);
        chk("pop55_udf",  32'(s_udf), 0);

        i_wren = 1'b1; i_wrdata = 16'h1234;
        tick();
        i_wren = 1'b0;
        chk("fwft_valid", 32'(f_rdvalid), 1);
        chk("fwft_data",  32'(f_rddata), 32'h1234);
        chk("std_no_rd",  32'(s_rdvalid), 0);
        i_rden = 1'b1;
        tick();
        chk("fwft_pop_valid", 32'(f_rdvalid), 0);
        chk("std_1234",       32'(s_rddata), 32'h1234);
        tick();
        i_rden = 1'b0;
        chk("udf_set",   32'(f_udf), 1);
        chk("udf_count", 32'(f_count), 0);
        i_clr_err = 1'b1;
        tick();
        chk("udf_clr", 32'(f_udf), 0);
        i_rden = 1'b1;
        tick();
        i_rden = 1'b0; i_clr_err = 1'b0;
        chk("udf_set_wins", 32'(f_udf), 1);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;

        i_wren = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_wrdata = 16'(16'h0021 + k);
            tick();
        end
        chk("pre_flush_count", 32'(s_count), 3);
        i_flush = 1'b1; i_wrdata = 16'h0024;
        tick();
        i_flush = 1'b0; i_wren = 1'b0;
        chk("flush_count", 32'(s_count), 0);
        chk("flush_empty", 32'(s_empty), 1);
        chk("flush_ovf",   32'(s_ovf), 0);
        chk("flush_f_valid", 32'(f_rdvalid), 0);

        i_rden = 1'b1;
        tick();
        i_rden = 1'b0;
        chk("pre_rst_udf", 32'(s_udf), 1);
        i_wren = 1'b1;
        i_wrdata = 16'h0031; tick();
        i_wrdata = 16'h0032; tick();
        i_wrdata = 16'h0033;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_count",   32'(s_count), 0);
        chk("async_empty",   32'(s_empty), 1);
        chk("async_full",    32'(s_full), 0);
        chk("async_udf",     32'(s_udf), 0);
        chk("async_rddata",  32'(s_rddata), 0);
        chk("async_rdvalid", 32'(s_rdvalid), 0);
        chk("async_f_valid", 32'(f_rdvalid), 0);
        chk("async_f_data",  32'(f_rddata), 0);
        i_wren = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        i_wren = 1'b1; i_wrdata = 16'h0041;
        tick();
        i_wren = 1'b0;
        chk("post_rst_f_head", 32'(f_rddata), 32'h0041);
        i_rden = 1'b1;
        tick();
        i_rden = 1'b0;
        chk("post_rst_s_data", 32'(s_rddata), 32'h0041);
        chk("post_rst_count",  32'(s_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
